pc_branch_unit: RTL
===================

// Module: pc_branch_unit
// PURPOSE
//  Program-counter stage of the 64-bit LEGv8 core. Holds the fetch PC and steps it by 4 each accepted fetch.
//  Consumes sign-extended branch offsets: imm26 for B, imm19 for CBZ/CBNZ. Redirects the PC on taken branches.
//  Sits between decode/branch-resolve (which supplies br_*) and instruction fetch (which takes pc_out).
//  Also flushes younger fetches and counts taken branches for perf monitoring.
// PARAMETERS
//  RESET_PC   64'h0  PC value loaded on reset
//  CNT_W      32     width of taken-branch counter (saturating)
// PORTS
//  clk           in   1   single clock, all state on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  fetch_ready   in   1   fetch stage accepts pc_out this cycle
//  pc_out        out  64  current fetch PC
//  pc_valid      out  1   pc_out is valid for fetch
//  br_valid      in   1   a branch instruction is resolved this cycle
//  br_type       in   2   pc_pkg::br_type_t: BR_NONE, BR_UNCOND(B, imm26), BR_COND(CBZ/CBNZ, imm19)
//  br_pc         in   64  PC of the resolved branch instruction
//  br_imm26      in   26  B offset, in words
//  br_imm19      in   19  CB offset, in words
//  br_cond       in   1   condition outcome for BR_COND (1 = taken)
//  halt          in   1   halt instruction retired
//  flush         out  1   1-cycle pulse: discard in-flight fetches
//  taken_cnt     out  CNT_W  number of taken branches since reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=BOOT, pc_out=RESET_PC, pc_valid=0, flush=0, taken_cnt=0.
//  FSM states BOOT, RUN, HALTED:
//   BOOT: first posedge after reset_n rises -> RUN; pc_valid=1 from then on, pc_out still RESET_PC.
//   RUN, per posedge, priority high->low:
//    1. halt=1 -> HALTED. pc_valid=0, pc_out held, any same-cycle branch ignored.
//    2. taken=1 -> pc_out<=target, flush<=1 for one cycle, taken_cnt++.
//       taken = br_valid & (br_type==BR_UNCOND | (br_type==BR_COND & br_cond)).
//       A taken branch overrides fetch_ready=0.
//    3. fetch_ready=1 -> pc_out<=pc_out+4.
//    4. otherwise pc_out holds (stall).
//   HALTED: absorbing; pc_valid=0, no PC change, no counting; only reset exits.
//  target = br_pc + (sext64(imm) << 2), wrap mod 2^64.
//   imm = br_imm26 for BR_UNCOND, br_imm19 for BR_COND. Sign bit: imm26[25] / imm19[18].
//  Sequential step pc_out+4 wraps mod 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0x0).
//  br_valid with br_type=BR_NONE, or BR_COND with br_cond=0: no redirect, no flush, no count.
//   Sequential/stall rules then apply.
//  flush is registered: high exactly the cycle pc_out first shows target; low otherwise, including BOOT/HALTED.
//  taken_cnt saturates at all-ones (no wrap).
//  Back-to-back taken branches: each redirects, flushes and counts; flush stays high for consecutive cycles.
//  Reset mid-operation: immediate return to reset values regardless of state or pending redirect.
//  Latency: branch resolve -> new pc_out: 1 cycle. Fetch accept -> pc+4: 1 cycle.
// STRUCTURE
//  pc_pkg holds:
//   br_type_t enum (BR_NONE=2'b00, BR_UNCOND=2'b01, BR_COND=2'b10; 2'b11 reserved, treated as BR_NONE)
//   pc_state_t enum {BOOT, RUN, HALTED}
//   INSTR_BYTES=4
//  Sub-module branch_target_gen (combinational): sign-extends the selected imm to 64, shifts left by 2, adds br_pc.
//  Top holds FSM, PC register, flush flop, saturating counter.
// TESTING
//  1. Reset, release, fetch_ready=1 -> pc_valid 0 then 1 at 0x0. pc_out 0x0,0x4,0x8,0xC on successive cycles.
//  2. fetch_ready=0 for 3 cycles at pc=0x8 -> pc_out holds 0x8, flush=0, taken_cnt unchanged.
//  3. B at br_pc=0x100, br_imm26=26'h3FFFFFE (-2) -> next pc_out=0xF8, flush=1 for 1 cycle, taken_cnt=1.
//     Same with fetch_ready=0 -> still redirects.
//  4. CBZ at br_pc=0x40, br_imm19=3, br_cond=1 -> pc_out=0x4C, taken_cnt++.
//     br_cond=0 -> pc_out=pc+4, no flush, no count.
//  5. halt=1 together with a taken B -> HALTED: pc_valid=0, pc_out unchanged, no flush.
//     Later stimulus ignored. reset_n pulse mid-cycle -> pc_out=RESET_PC asynchronously.
//  6. CNT_W=2 build, 5 back-to-back taken branches -> flush high 5 cycles, taken_cnt saturates at 2'b11.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the LEGv8 program-counter stage.
package pc_pkg;

    // Branch class coming from decode/branch-resolve. 2'b11 is reserved
    // and behaves like BR_NONE.
    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_UNCOND = 2'b01,
        BR_COND   = 2'b10
    } br_type_t;

    // PC stage control state.
    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } pc_state_t;

    // Size of one LEGv8 instruction in bytes.
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_target_gen.sv
// Branch target adder: sign-extends the word offset of the selected
// branch form, converts it to a byte offset and adds it to the branch PC.
module branch_target_gen (
    input  logic [63:0] i_br_pc,
    input  logic        i_sel_uncond,
    input  logic [25:0] i_imm26,
    input  logic [18:0] i_imm19,
    output logic [63:0] o_target
);

    logic [63:0] w_imm_sext;

    // Pick the offset field (B uses imm26, CBZ/CBNZ use imm19), scale by 4, add to br_pc.
    always_comb begin
        if (i_sel_uncond) begin
            w_imm_sext = {{38{i_imm26[25]}}, i_imm26};
        end else begin
            w_imm_sext = {{45{i_imm19[18]}}, i_imm19};
        end
        o_target = i_br_pc + {w_imm_sext[61:0], 2'b00};
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter stage: holds the fetch PC, steps it on accepted fetches,
// redirects on taken branches with a one-cycle flush pulse, and counts
// taken branches in a saturating counter.
//
// Handshake: the PC in pc_out is offered to fetch whenever pc_valid=1; a
// fetch is accepted on a posedge where pc_valid=1 and fetch_ready=1, and
// pc_out moves to pc_out+4 on that edge. A taken branch wins over the
// handshake and loads the target whether or not fetch was ready.
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fetch_ready,
    output logic [63:0]      pc_out,
    output logic             pc_valid,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [63:0]      br_pc,
    input  logic [25:0]      br_imm26,
    input  logic [18:0]      br_imm19,
    input  logic             br_cond,
    input  logic             halt,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt,
    output pc_state_t        o_dbg_state
);

    pc_state_t        r_state;
    logic [63:0]      r_pc;
    logic             r_valid;
    logic             r_flush;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_uncond;
    logic             w_is_cond;
    logic             w_taken;
    logic [63:0]      w_target;

    // Decode whether the resolved branch redirects the PC.
    always_comb begin
        w_is_uncond = (br_type == BR_UNCOND);
        w_is_cond   = (br_type == BR_COND);
        w_taken     = br_valid & (w_is_uncond | (w_is_cond & br_cond));
    end

    branch_target_gen u_target_gen (
        .i_br_pc      (br_pc),
        .i_sel_uncond (w_is_uncond),
        .i_imm26      (br_imm26),
        .i_imm19      (br_imm19),
        .o_target     (w_target)
    );

    // Control FSM with PC register, flush pulse and saturating taken counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                    r_flush <= 1'b0;
                end
                RUN: begin
                    if (halt) begin
                        // Halt wins over any branch resolved in the same cycle.
                        r_state <= HALTED;
                        r_valid <= 1'b0;
                        r_flush <= 1'b0;
                    end else if (w_taken) begin
                        r_pc    <= w_target;
                        r_flush <= 1'b1;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_flush <= 1'b0;
                        if (fetch_ready) begin
                            r_pc <= r_pc + 64'(INSTR_BYTES);
                        end
                    end
                end
                HALTED: begin
                    r_valid <= 1'b0;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= BOOT;
                    r_valid <= 1'b0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign pc_valid    = r_valid;
    assign flush       = r_flush;
    assign taken_cnt   = r_cnt;
    assign o_dbg_state = r_state;

endmodule
